// File: rtl/icache_pkg.sv
// Shared constants and FSM encoding for the direct-mapped instruction cache.
package icache_pkg;

    localparam int XLEN           = 32;
    localparam int INDEX_W_DEF    = 4;
    localparam int WORD_OFF_W_DEF = 2;

    typedef enum logic {
        IC_IDLE = 1'b0,
        IC_FILL = 1'b1
    } ic_state_e;

endpackage

// File: rtl/icache_line_array.sv
// Valid/tag/data storage for the instruction cache.
// Combinational read port and synchronous write port.
module icache_line_array
    import icache_pkg::*;
#(
    parameter int INDEX_W    = INDEX_W_DEF,
    parameter int WORD_OFF_W = WORD_OFF_W_DEF,
    parameter int TAG_W      = XLEN - INDEX_W_DEF - WORD_OFF_W_DEF - 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_W-1:0]    rd_idx_i,
    input  logic [WORD_OFF_W-1:0] rd_off_i,
    output logic                  rd_valid_o,
    output logic [TAG_W-1:0]      rd_tag_o,
    output logic [XLEN-1:0]       rd_word_o,
    input  logic                  wr_en_i,
    input  logic [INDEX_W-1:0]    wr_idx_i,
    input  logic [WORD_OFF_W-1:0] wr_off_i,
    input  logic [XLEN-1:0]       wr_data_i,
    input  logic                  clr_en_i,
    input  logic [INDEX_W-1:0]    clr_idx_i,
    input  logic                  set_en_i,
    input  logic [TAG_W-1:0]      set_tag_i
);

    localparam int LINES = 1 << INDEX_W;
    localparam int WORDS = 1 << WORD_OFF_W;

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [XLEN-1:0]  data_q [LINES][WORDS];

    assign rd_valid_o = valid_q[rd_idx_i];
    assign rd_tag_o   = tag_q[rd_idx_i];
    assign rd_word_o  = data_q[rd_idx_i][rd_off_i];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            if (clr_en_i) begin
                valid_q[clr_idx_i] <= 1'b0;
            end
            if (set_en_i) begin
                valid_q[wr_idx_i] <= 1'b1;
            end
        end
    end

    // Tag and data contents are don't-care while the valid bit is clear.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            data_q[wr_idx_i][wr_off_i] <= wr_data_i;
        end
        if (set_en_i) begin
            tag_q[wr_idx_i] <= set_tag_i;
        end
    end

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache.
// Same-cycle hits; misses fill the whole line word by word from memory.
module icache
    import icache_pkg::*;
#(
    parameter int INDEX_W    = INDEX_W_DEF,
    parameter int WORD_OFF_W = WORD_OFF_W_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rdy,
    input  logic            if_req,
    input  logic [XLEN-1:0] if_pc,
    output logic            inst_valid,
    output logic [XLEN-1:0] inst,
    output logic            mem_fetch_en,
    output logic [XLEN-1:0] mem_addr,
    input  logic            mem_valid,
    input  logic [XLEN-1:0] mem_data
);

    localparam int TAG_W = XLEN - INDEX_W - WORD_OFF_W - 2;
    localparam logic [WORD_OFF_W-1:0] LAST = '1;

    logic [WORD_OFF_W-1:0] pc_off;
    logic [INDEX_W-1:0]    pc_idx;
    logic [TAG_W-1:0]      pc_tag;

    assign pc_off = if_pc[WORD_OFF_W+1:2];
    assign pc_idx = if_pc[WORD_OFF_W+2 +: INDEX_W];
    assign pc_tag = if_pc[XLEN-1 -: TAG_W];

    ic_state_e             state_q, state_d;
    logic [WORD_OFF_W-1:0] cnt_q, cnt_d;
    logic [TAG_W-1:0]      tag_q, tag_d;
    logic [INDEX_W-1:0]    idx_q, idx_d;
    logic [XLEN-1:0]       addr_q, addr_d;
    logic                  fen_q, fen_d;

    logic                  rd_valid;
    logic [TAG_W-1:0]      rd_tag;
    logic [XLEN-1:0]       rd_word;
    logic                  hit;
    logic                  start;
    logic                  word_we;
    logic                  done;

    // The line under fill has its valid bit cleared, so it reads as a miss.
    assign hit          = rd_valid & (rd_tag == pc_tag);
    assign inst_valid   = if_req & hit;
    assign inst         = rd_word;
    assign mem_fetch_en = fen_q;
    assign mem_addr     = addr_q;

    icache_line_array #(
        .INDEX_W    (INDEX_W),
        .WORD_OFF_W (WORD_OFF_W),
        .TAG_W      (TAG_W)
    ) u_lines (
        .clk        (clk),
        .rst        (rst),
        .rd_idx_i   (pc_idx),
        .rd_off_i   (pc_off),
        .rd_valid_o (rd_valid),
        .rd_tag_o   (rd_tag),
        .rd_word_o  (rd_word),
        .wr_en_i    (word_we & rdy),
        .wr_idx_i   (idx_q),
        .wr_off_i   (cnt_q),
        .wr_data_i  (mem_data),
        .clr_en_i   (start & rdy),
        .clr_idx_i  (pc_idx),
        .set_en_i   (done & rdy),
        .set_tag_i  (tag_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IC_IDLE;
            cnt_q   <= '0;
            tag_q   <= '0;
            idx_q   <= '0;
            addr_q  <= '0;
            fen_q   <= 1'b0;
        end else if (rdy) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tag_q   <= tag_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            fen_q   <= fen_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IC_IDLE: if (if_req && !hit) state_d = IC_FILL;
            IC_FILL: if (mem_valid && cnt_q == LAST) state_d = IC_IDLE;
            default: state_d = IC_IDLE;
        endcase
    end

    always_comb begin
        start   = 1'b0;
        word_we = 1'b0;
        done    = 1'b0;
        unique case (state_q)
            IC_IDLE: start = if_req & ~hit;
            IC_FILL: begin
                word_we = mem_valid;
                done    = mem_valid & (cnt_q == LAST);
            end
            default: ;
        endcase
    end

    always_comb begin
        cnt_d  = cnt_q;
        tag_d  = tag_q;
        idx_d  = idx_q;
        addr_d = addr_q;
        fen_d  = fen_q;
        if (start) begin
            cnt_d  = '0;
            tag_d  = pc_tag;
            idx_d  = pc_idx;
            addr_d = {pc_tag, pc_idx, {WORD_OFF_W{1'b0}}, 2'b00};
            fen_d  = 1'b1;
        end else if (done) begin
            cnt_d  = '0;
            addr_d = '0;
            fen_d  = 1'b0;
        end else if (word_we) begin
            cnt_d  = cnt_q + WORD_OFF_W'(1);
            addr_d = addr_q + 32'd4;
        end
    end

endmodule

// File: tb/tb_icache.sv
// Directed and randomized checks of icache against a line-residency model.
module tb_icache;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        if_req;
    logic [31:0] if_pc;
    logic        inst_valid;
    logic [31:0] inst;
    logic        mem_fetch_en;
    logic [31:0] mem_addr;
    logic        mem_valid;
    logic [31:0] mem_data;

    int total = 0;
    int bad   = 0;

    // Which 16-byte memory block each line holds (ref_v=0: none).
    logic [31:0] ref_base [16];
    bit          ref_v    [16];

    icache dut (
        .clk          (clk),
        .rst          (rst),
        .rdy          (rdy),
        .if_req       (if_req),
        .if_pc        (if_pc),
        .inst_valid   (inst_valid),
        .inst         (inst),
        .mem_fetch_en (mem_fetch_en),
        .mem_addr     (mem_addr),
        .mem_valid    (mem_valid),
        .mem_data     (mem_data)
    );

    always #10 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string name, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Present a lookup and compare against the residency model.
    task automatic probe(input logic [31:0] pc, input string name);
        logic [3:0] idx;
        bit         hit;
        idx    = pc[7:4];
        hit    = ref_v[idx] && (ref_base[idx] == (pc & 32'hFFFF_FFF0));
        if_req = 1'b1;
        if_pc  = pc;
        #1;
        chk({name, "_valid"}, {31'd0, inst_valid}, {31'd0, hit});
        if (hit) chk({name, "_inst"}, inst, memf(pc));
    endtask

    task automatic start_miss(input logic [31:0] pc, input string name);
        probe(pc, name);
        tick();
        ref_v[pc[7:4]] = 1'b0;
        chk({name, "_start_en"}, {31'd0, mem_fetch_en}, 32'd1);
        chk({name, "_start_addr"}, mem_addr, pc & 32'hFFFF_FFF0);
    endtask

    // Idle for gap cycles with junk on the data bus, then pulse one word.
    task automatic serve(input int gap, input logic [31:0] exp);
        mem_valid = 1'b0;
        for (int g = 0; g < gap; g++) begin
            mem_data = $urandom;
            tick();
            chk("gap_addr", mem_addr, exp);
        end
        chk("word_addr", mem_addr, exp);
        chk("word_en", {31'd0, mem_fetch_en}, 32'd1);
        mem_valid = 1'b1;
        mem_data  = memf(exp);
        tick();
        mem_valid = 1'b0;
        mem_data  = $urandom;
    endtask

    task automatic finish_fill(input logic [31:0] base);
        chk("done_en", {31'd0, mem_fetch_en}, 32'd0);
        chk("done_addr", mem_addr, 32'd0);
        ref_v[base[7:4]]    = 1'b1;
        ref_base[base[7:4]] = base;
    endtask

    task automatic fill(input logic [31:0] base, input int g0, input int g1,
                        input int g2, input int g3);
        serve(g0, base);
        serve(g1, base + 32'd4);
        serve(g2, base + 32'd8);
        serve(g3, base + 32'd12);
        finish_fill(base);
    endtask

    initial begin
        logic [31:0] pc;
        for (int i = 0; i < 16; i++) begin
            ref_v[i]    = 1'b0;
            ref_base[i] = '0;
        end
        rst       = 1'b1;
        rdy       = 1'b1;
        if_req    = 1'b0;
        if_pc     = '0;
        mem_valid = 1'b0;
        mem_data  = '0;
        tick();
        tick();
        chk("reset_en", {31'd0, mem_fetch_en}, 32'd0);
        chk("reset_addr", mem_addr, 32'd0);
        rst = 1'b0;

        // Cold miss at 0x0.
        start_miss(32'h0000_0000, "cold");
        fill(32'h0000_0000, 2, 2, 2, 2);
        probe(32'h0000_0008, "cold_hit");
        tick();

        // Conflict miss on index 0.
        start_miss(32'h0000_0100, "conf");
        fill(32'h0000_0100, 1, 0, 3, 1);
        probe(32'h0000_0000, "conf_old");
        probe(32'h0000_0104, "conf_new");
        tick();

        // Irregular response spacing with junk on the bus between pulses.
        start_miss(32'h0000_2040, "irr");
        fill(32'h0000_2040, 7, 20, 3, 0);
        probe(32'h0000_204C, "irr_hit");
        probe(32'h0000_2044, "irr_hit2");
        tick();

        // Stalled miss in IDLE must not start a fill.
        rdy    = 1'b0;
        if_req = 1'b1;
        if_pc  = 32'h0000_3050;
        repeat (3) tick();
        chk("stall_idle_en", {31'd0, mem_fetch_en}, 32'd0);
        chk("stall_idle_addr", mem_addr, 32'd0);
        rdy = 1'b1;
        tick();
        ref_v[5] = 1'b0;
        chk("stall_start_addr", mem_addr, 32'h0000_3050);
        serve(1, 32'h0000_3050);
        serve(2, 32'h0000_3054);
        rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            mem_data = $urandom;
            tick();
            chk("stall_addr", mem_addr, 32'h0000_3058);
            chk("stall_en", {31'd0, mem_fetch_en}, 32'd1);
        end
        rdy = 1'b1;
        serve(0, 32'h0000_3058);
        serve(3, 32'h0000_305C);
        finish_fill(32'h0000_3050);
        probe(32'h0000_3054, "stall_hit");
        tick();

        // Reset in the middle of a fill.
        start_miss(32'h0000_4000, "rst");
        serve(0, 32'h0000_4000);
        serve(1, 32'h0000_4004);
        rst    = 1'b1;
        if_req = 1'b0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 16; i++) ref_v[i] = 1'b0;
        chk("rst_en", {31'd0, mem_fetch_en}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        probe(32'h0000_0104, "rst_inv0");
        probe(32'h0000_3050, "rst_inv5");
        probe(32'h0000_2040, "rst_inv4");
        if_req = 1'b0;
        tick();
        start_miss(32'h0000_4000, "rerq");
        fill(32'h0000_4000, 0, 2, 0, 1);
        probe(32'h0000_400C, "rerq_hit");
        tick();

        // Hit under fill to another line; no second fill on the busy line.
        start_miss(32'h0000_3050, "l5");
        fill(32'h0000_3050, 1, 0, 2, 0);
        start_miss(32'h0000_0000, "huf");
        serve(0, 32'h0000_0000);
        probe(32'h0000_3054, "huf_other");
        probe(32'h0000_4000, "huf_busy_old");
        probe(32'h0000_0008, "huf_busy_new");
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("huf_hold_addr", mem_addr, 32'h0000_0004);
            chk("huf_hold_en", {31'd0, mem_fetch_en}, 32'd1);
        end
        serve(0, 32'h0000_0004);
        serve(1, 32'h0000_0008);
        serve(0, 32'h0000_000C);
        finish_fill(32'h0000_0000);
        probe(32'h0000_0008, "huf_done");
        tick();

        // Random lookups against the residency model.
        for (int n = 0; n < 60; n++) begin
            pc = (32'($urandom_range(0, 3)) << 12)
               | (32'($urandom_range(0, 15)) << 4)
               | (32'($urandom_range(0, 3)) << 2);
            if (ref_v[pc[7:4]] && ref_base[pc[7:4]] == (pc & 32'hFFFF_FFF0)) begin
                probe(pc, "rnd_hit");
            end else begin
                start_miss(pc, "rnd_miss");
                fill(pc & 32'hFFFF_FFF0,
                     $urandom_range(0, 4), $urandom_range(0, 4),
                     $urandom_range(0, 4), $urandom_range(0, 4));
                probe(pc, "rnd_after");
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
